sar_ctrl_param: RTL and testbench
=================================

SAR_CTRL_PARAM -- requirements
Module: sar_ctrl_param

Interface
REQ-001 Parameter NBITS, default 10, SHALL set the conversion resolution; legal range 2..16.
REQ-002 Parameter SAMPLE_CYC, default 4, SHALL set the number of cycles in the sampling phase; legal range 1..255.
REQ-003 Parameter TMO_CYC, default 15, SHALL set the comparator decision timeout in cycles; legal range 1..255; used only under SAR_TIMEOUT_EN.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  conversion request; sampled only in IDLE.
REQ-007 outp  in  1  comparator positive output, synchronous to clk.
REQ-008 outn  in  1  comparator negative output, synchronous to clk.
REQ-009 comp_clk  out  1  comparator strobe.
REQ-010 creset  out  1  comparator reset/precharge.
REQ-011 clc  out  NBITS  DAC trial code.
REQ-012 dout  out  NBITS  last completed conversion result.
REQ-013 busy  out  1  conversion in progress.
REQ-014 done  out  1  one-cycle result-valid pulse.
REQ-015 err  out  1  sticky timeout flag; tied 0 without SAR_TIMEOUT_EN.

Function
REQ-016 Comparator states SHALL decode as follows: outp=1,outn=1 is precharged; outp=1,outn=0 is decision 1; outp=0,outn=1 is decision 0; outp=0,outn=0 is invalid and SHALL be treated as "no decision".
REQ-017 The FSM SHALL have exactly these states: IDLE, SAMPLE, STROBE, WAIT_DEC, RECOVER, DONE.
REQ-018 IDLE: busy=0, creset=1, comp_clk=0; start=1 SHALL move to SAMPLE on the next edge, set busy=1, clear clc to 0 and set bit index i=NBITS-1.
REQ-019 SAMPLE SHALL last exactly SAMPLE_CYC cycles with creset=1 and clc=0, then move to STROBE.
REQ-020 STROBE SHALL last one cycle with clc[i]=1 as the trial bit, creset=0 and comp_clk=1, then move to WAIT_DEC.
REQ-021 WAIT_DEC SHALL keep comp_clk=1 and creset=0, and SHALL stay until a valid decision arrives; on that edge clc[i] SHALL take the decision value and the FSM SHALL move to RECOVER.
REQ-022 RECOVER SHALL drive comp_clk=0 and creset=1 until the precharged state is seen; then, if i>0, it SHALL decrement i and move to STROBE, otherwise it SHALL move to DONE.
REQ-023 DONE SHALL last one cycle: dout<=clc, done=1, busy=0 on the following cycle, then return to IDLE.
REQ-024 Minimum conversion latency from start to done SHALL be 1+SAMPLE_CYC+3*NBITS cycles, reached when each decision and each recovery resolves in one cycle.
REQ-025 start asserted while busy=1 SHALL be ignored; start in the DONE cycle SHALL also be ignored.
REQ-026 dout SHALL hold its value until the next DONE; clc SHALL remain visible after DONE until the next start.

Reset
REQ-027 rst=1 SHALL on the next edge force IDLE with clc=0, dout=0, busy=0, done=0, err=0, comp_clk=0, creset=1, i=NBITS-1.
REQ-028 rst asserted mid-conversion SHALL abort with no done pulse, and dout SHALL be cleared.

Configuration
REQ-029 With SAR_TIMEOUT_EN defined, WAIT_DEC SHALL count cycles; if no valid decision arrives within TMO_CYC cycles, clc[i] SHALL be forced to 0, err SHALL be set (cleared only by rst), and the FSM SHALL go to RECOVER.
REQ-030 With SAR_TIMEOUT_EN defined, RECOVER SHALL apply the same TMO_CYC limit, then proceed as if precharged and set err.
REQ-031 Without SAR_TIMEOUT_EN, no timeout counter SHALL exist, WAIT_DEC and RECOVER SHALL wait indefinitely, and err SHALL be constant 0.

Verification
REQ-032 NBITS=10, SAMPLE_CYC=4, comparator model emulating input 0x2A5 with 1-cycle response -> done after 35 cycles, dout=0x2A5, err=0.
REQ-033 All decisions 1, then all decisions 0 -> dout=0x3FF, then dout=0x000; clc shows exactly one new trial bit per STROBE.
REQ-034 start pulsed during WAIT_DEC of bit 5 -> ignored; exactly one done pulse; result unchanged.
REQ-035 rst asserted in WAIT_DEC of bit 3 -> next cycle IDLE, creset=1, clc=0, dout=0, no done pulse.
REQ-036 SAR_TIMEOUT_EN, TMO_CYC=15, outp=outn=0 held at bit 9 -> after 15 cycles clc[9]=0, err=1; conversion completes and err stays 1 until rst.
REQ-037 NBITS=4, SAMPLE_CYC=1, comparator model emulating input 0xB -> dout=0xB after 14 cycles.

Source files
------------

// File: rtl/sar_ctrl_param.sv
// sar_ctrl_param -- successive-approximation ADC sequencer.
// Walks the DAC trial code from MSB to LSB: sample, strobe the comparator,
// wait for its decision, wait for it to precharge again, next bit.
// Optional build macro SAR_TIMEOUT_EN adds a TMO_CYC-cycle watchdog on the
// decision and precharge waits together with a sticky err flag.
// Without it the waits are unbounded and err is tied low.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | no conversion; comparator precharged; waits for start
//   SAMPLE   | input sampling for SAMPLE_CYC cycles, trial code cleared
//   STROBE   | trial bit clc[i] set, comparator clocked (one cycle)
//   WAIT_DEC | comparator clocked, waiting for a valid decision
//   RECOVER  | comparator precharging, waiting for outp=outn=1
//   DONE     | result latched into dout, one-cycle done pulse

module sar_ctrl_param #(
  parameter int NBITS      = 10,
  parameter int SAMPLE_CYC = 4,
  parameter int TMO_CYC    = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             outp,
  input  logic             outn,
  output logic             comp_clk,
  output logic             creset,
  output logic [NBITS-1:0] clc,
  output logic [NBITS-1:0] dout,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SAMPLE   = 3'd1;
  localparam logic [2:0] ST_STROBE   = 3'd2;
  localparam logic [2:0] ST_WAIT_DEC = 3'd3;
  localparam logic [2:0] ST_RECOVER  = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  localparam int IW = (NBITS > 2) ? $clog2(NBITS) : 1;

  localparam logic [IW-1:0] IDX_MSB     = IW'(NBITS - 1);
  localparam logic [7:0]    SAMPLE_LOAD = 8'(SAMPLE_CYC - 1);

  // Reject parameter sets outside the supported ranges at elaboration.
  if (NBITS < 2 || NBITS > 16 || SAMPLE_CYC < 1 || SAMPLE_CYC > 255 ||
      TMO_CYC < 1 || TMO_CYC > 255) begin : g_param_check
    $error("sar_ctrl_param: parameter out of legal range");
  end

  logic [2:0]    state;
  logic [IW-1:0] bit_idx;
  logic [IW-1:0] next_idx;
  logic [7:0]    samp_cnt;

  logic dec_valid;
  logic dec_bit;
  logic precharged;
  logic wait_to;
  logic rec_to;

  // Comparator decode: 10 -> one, 01 -> zero, 11 -> precharged, 00 -> nothing.
  assign dec_valid  = outp ^ outn;
  assign dec_bit    = outp;
  assign precharged = outp & outn;
  assign next_idx   = bit_idx - 1'b1;

`ifdef SAR_TIMEOUT_EN
  localparam logic [7:0] TMO_LOAD = 8'(TMO_CYC - 1);

  logic [7:0] tmo_cnt;
  logic       tmo_zero;
  logic       err_q;

  assign tmo_zero = (tmo_cnt == 8'd0);
  assign wait_to  = (state == ST_WAIT_DEC) && !dec_valid  && tmo_zero;
  assign rec_to   = (state == ST_RECOVER)  && !precharged && tmo_zero;
  assign err      = err_q;

  // Watchdog down-counter, reloaded on entry to WAIT_DEC and RECOVER; err is sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      if (state == ST_STROBE ||
          (state == ST_WAIT_DEC && (dec_valid || wait_to))) begin
        tmo_cnt <= TMO_LOAD;
      end else if ((state == ST_WAIT_DEC || state == ST_RECOVER) && !tmo_zero) begin
        tmo_cnt <= tmo_cnt - 1'b1;
      end
      if (wait_to || rec_to) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign wait_to = 1'b0;
  assign rec_to  = 1'b0;
  assign err     = 1'b0;
`endif

  // Conversion sequencer: state, bit index, trial code and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      bit_idx  <= IDX_MSB;
      samp_cnt <= 8'd0;
      clc      <= '0;
      dout     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_SAMPLE;
            clc      <= '0;
            bit_idx  <= IDX_MSB;
            samp_cnt <= SAMPLE_LOAD;
          end
        end
        ST_SAMPLE: begin
          if (samp_cnt == 8'd0) begin
            state        <= ST_STROBE;
            clc[bit_idx] <= 1'b1;
          end else begin
            samp_cnt <= samp_cnt - 1'b1;
          end
        end
        ST_STROBE: begin
          state <= ST_WAIT_DEC;
        end
        ST_WAIT_DEC: begin
          if (dec_valid) begin
            clc[bit_idx] <= dec_bit;
            state        <= ST_RECOVER;
          end else if (wait_to) begin
            clc[bit_idx] <= 1'b0;
            state        <= ST_RECOVER;
          end
        end
        ST_RECOVER: begin
          if (precharged || rec_to) begin
            if (bit_idx != '0) begin
              bit_idx       <= next_idx;
              clc[next_idx] <= 1'b1;
              state         <= ST_STROBE;
            end else begin
              // clc is final here, so dout is valid in the same cycle as done.
              dout  <= clc;
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status and comparator controls decoded from the state register.
  always_comb begin
    busy     = (state != ST_IDLE);
    done     = (state == ST_DONE);
    comp_clk = (state == ST_STROBE) || (state == ST_WAIT_DEC);
    creset   = !((state == ST_STROBE) || (state == ST_WAIT_DEC));
  end

endmodule

// File: tb/tb_sar_ctrl_param.sv
// Bench for sar_ctrl_param: a 10-bit/4-cycle instance and a 4-bit/1-cycle
// instance, each driven by an ideal comparator model that compares a held
// analog value against the DAC trial code. With the ideal model the expected
// result is simply the input value.
module tb_sar_ctrl_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start_a = 1'b0;
  logic       outp_a = 1'b1;
  logic       outn_a = 1'b1;
  logic       comp_clk_a, creset_a, busy_a, done_a, err_a;
  logic [9:0] clc_a, dout_a;

  logic       start_b = 1'b0;
  logic       outp_b = 1'b1;
  logic       outn_b = 1'b1;
  logic       comp_clk_b, creset_b, busy_b, done_b, err_b;
  logic [3:0] clc_b, dout_b;

  int checks = 0;
  int errors = 0;

  logic [9:0] vin_a = '0;
  logic [3:0] vin_b = '0;
  bit         slow = 1'b0;
  bit         stuck_arm = 1'b0;

  sar_ctrl_param #(.NBITS(10), .SAMPLE_CYC(4), .TMO_CYC(15)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .outp(outp_a), .outn(outn_a),
    .comp_clk(comp_clk_a), .creset(creset_a), .clc(clc_a), .dout(dout_a),
    .busy(busy_a), .done(done_a), .err(err_a));

  sar_ctrl_param #(.NBITS(4), .SAMPLE_CYC(1), .TMO_CYC(15)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .outp(outp_b), .outn(outn_b),
    .comp_clk(comp_clk_b), .creset(creset_b), .clc(clc_b), .dout(dout_b),
    .busy(busy_b), .done(done_b), .err(err_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Comparator model A: optional random response delay, optional stuck 00 phase.
  initial begin : resp_a
    logic prev_cc;
    bit   stuck_now;
    int   dly;
    prev_cc   = 1'b0;
    stuck_now = 1'b0;
    dly       = 0;
    forever begin
      @(posedge clk);
      #1;
      if (comp_clk_a !== prev_cc) begin
        dly = slow ? int'($urandom_range(0, 3)) : 0;
        stuck_now = 1'b0;
        if (comp_clk_a === 1'b1 && stuck_arm) begin
          stuck_now = 1'b1;
          stuck_arm = 1'b0;
        end
        prev_cc = comp_clk_a;
      end
      if (comp_clk_a === 1'b1) begin
        if (stuck_now) begin
          outp_a = 1'b0; outn_a = 1'b0;
        end else if (dly > 0) begin
          if ($urandom_range(0, 1) == 0) begin outp_a = 1'b0; outn_a = 1'b0; end
          else begin outp_a = 1'b1; outn_a = 1'b1; end
          dly--;
        end else begin
          outp_a = (vin_a >= clc_a);
          outn_a = !(vin_a >= clc_a);
        end
      end else begin
        if (dly > 0) begin
          case ($urandom_range(0, 2))
            0: begin outp_a = 1'b0; outn_a = 1'b0; end
            1: begin outp_a = 1'b1; outn_a = 1'b0; end
            default: begin outp_a = 1'b0; outn_a = 1'b1; end
          endcase
          dly--;
        end else begin
          outp_a = 1'b1; outn_a = 1'b1;
        end
      end
    end
  end

  // Comparator model B: ideal, one-cycle response.
  initial begin : resp_b
    forever begin
      @(posedge clk);
      #1;
      if (comp_clk_b === 1'b1) begin
        outp_b = (vin_b >= clc_b);
        outn_b = !(vin_b >= clc_b);
      end else begin
        outp_b = 1'b1; outn_b = 1'b1;
      end
    end
  end

  // One conversion on instance A. poke_kind: 0 none, 1 start pulse, 2 reset,
  // applied in the WAIT_DEC cycle of bit poke_bit.
  task automatic conv_a(input logic [9:0] vin, input bit slow_i, input int poke_bit,
                        input int poke_kind, input bit stuck_i, input logic [9:0] exp_dout);
    int cyc, bitn, poke_at, s9_cyc, err_cyc, nd;
    bit prev_cc, aborted;
    logic [9:0] hi, expc;
    logic bit9_at_err;
    vin_a = vin;
    slow = slow_i;
    stuck_arm = stuck_i;
    @(posedge clk); #1;
    chk("idle_busy", busy_a, 0);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    cyc = 1;
    chk("sample_busy", busy_a, 1);
    chk("sample_clc", clc_a, 0);
    chk("sample_creset", creset_a, 1);
    bitn = 10; prev_cc = 1'b0; poke_at = -10; aborted = 1'b0;
    s9_cyc = -1; err_cyc = -1; bit9_at_err = 1'bx;
    while (done_a !== 1'b1 && !aborted && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == poke_at + 1) begin
        start_a = 1'b0;
        if (poke_kind == 2) begin
          rst = 1'b0;
          chk("rst_busy", busy_a, 0);
          chk("rst_done", done_a, 0);
          chk("rst_creset", creset_a, 1);
          chk("rst_comp_clk", comp_clk_a, 0);
          chk("rst_clc", clc_a, 0);
          chk("rst_dout", dout_a, 0);
          aborted = 1'b1;
        end
      end
      if (!aborted && comp_clk_a === 1'b1 && !prev_cc) begin
        bitn--;
        hi = exp_dout >> (bitn + 1);
        hi = hi << (bitn + 1);
        expc = hi | (10'd1 << bitn);
        chk("trial_clc", clc_a, expc);
        if (bitn == 9) s9_cyc = cyc;
        if (bitn == poke_bit) poke_at = cyc + 1;
      end
      prev_cc = (comp_clk_a === 1'b1);
      if (err_a === 1'b1 && err_cyc < 0) begin
        err_cyc = cyc;
        bit9_at_err = clc_a[9];
      end
      if (cyc == poke_at) begin
        if (poke_kind == 1) start_a = 1'b1;
        else if (poke_kind == 2) rst = 1'b1;
      end
    end
    if (poke_kind == 2) begin
      chk("rst_aborted", aborted, 1);
      nd = 0;
      repeat (40) begin
        @(posedge clk); #1;
        if (done_a === 1'b1) nd++;
      end
      chk("rst_no_done", nd, 0);
      chk("rst_stays_idle", busy_a, 0);
      chk("rst_dout_held", dout_a, 0);
      return;
    end
    chk("conv_done", done_a, 1);
    if (!slow_i && !stuck_i) chk("latency", cyc, 35);
    chk("dout", dout_a, exp_dout);
    chk("err", err_a, stuck_i ? 1 : 0);
    if (stuck_i) begin
      chk("tmo_len", err_cyc - s9_cyc, 16);
      chk("tmo_bit9", bit9_at_err, 0);
    end
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("post_busy", busy_a, 0);
    chk("post_done", done_a, 0);
    chk("post_clc", clc_a, exp_dout);
    nd = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done_a === 1'b1) nd++;
    end
    chk("single_done", nd, 0);
    chk("dout_hold", dout_a, exp_dout);
    chk("idle_hold", busy_a, 0);
  endtask

  task automatic conv_b(input logic [3:0] vin);
    int cyc;
    vin_b = vin;
    @(posedge clk); #1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    cyc = 1;
    while (done_b !== 1'b1 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("b_done", done_b, 1);
    chk("b_latency", cyc, 14);
    chk("b_dout", dout_b, vin);
    @(posedge clk); #1;
    chk("b_idle", busy_b, 0);
  endtask

  initial begin
    logic [9:0] v;
    bit s;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy_a, 0);
    chk("reset_done", done_a, 0);
    chk("reset_creset", creset_a, 1);
    chk("reset_comp_clk", comp_clk_a, 0);
    chk("reset_clc", clc_a, 0);
    chk("reset_dout", dout_a, 0);
    chk("reset_err", err_a, 0);
    chk("reset_b_busy", busy_b, 0);
    chk("reset_b_dout", dout_b, 0);
    rst = 1'b0;

    conv_a(10'h2A5, 1'b0, -1, 0, 1'b0, 10'h2A5);
    conv_a(10'h3FF, 1'b0, -1, 0, 1'b0, 10'h3FF);
    conv_a(10'h000, 1'b0, -1, 0, 1'b0, 10'h000);
    conv_a(10'h15A, 1'b0, 5, 1, 1'b0, 10'h15A);
    for (int k = 0; k < 8; k++) begin
      v = 10'($urandom_range(0, 1023));
      s = bit'($urandom_range(0, 1));
      conv_a(v, s, -1, 0, 1'b0, v);
    end
    conv_a(10'h0F0, 1'b0, 3, 2, 1'b0, 10'h0F0);
    conv_a(10'h1C3, 1'b1, -1, 0, 1'b0, 10'h1C3);

`ifdef SAR_TIMEOUT_EN
    conv_a(10'h2A5, 1'b0, -1, 0, 1'b1, 10'h1FF);
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", err_a, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("err_cleared", err_a, 0);
`endif

    conv_b(4'hB);
    for (int k = 0; k < 3; k++) begin
      conv_b(4'($urandom_range(0, 15)));
    end
    chk("b_err", err_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
